// File: rtl/a2f_iq_packer.sv
// Packs 24-bit AFE RX IQ pairs into 32-bit FT600 write words (4 pairs -> 3 words),
// with a latched flush that emits any partially packed word with trimmed byte enables.
module a2f_iq_packer #(
   parameter int IQ_PAIR_WIDTH = 24,  // only 24 is supported
   parameter int FT_DATA_WIDTH = 32   // only 32 is supported
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [IQ_PAIR_WIDTH-1:0] iq_data,
   input  logic                     iq_valid,
   output logic                     iq_ready,
   input  logic                     flush,
   output logic [FT_DATA_WIDTH-1:0] ft_data,
   output logic [3:0]               ft_be,
   output logic                     ft_valid,
   input  logic                     ft_ready,
   output logic [1:0]               phase,
   output logic                     flush_pending
);

   typedef enum logic [1:0] {
      PH0 = 2'd0,
      PH1 = 2'd1,
      PH2 = 2'd2,
      PH3 = 2'd3
   } phase_t;

   phase_t      phase_q, phase_d;
   logic [23:0] residual_q, residual_d;
   logic [31:0] data_d;
   logic [3:0]  be_d;
   logic        valid_d;
   logic        flush_pending_d;

   logic slot_free;
   logic accept;
   logic flush_exec;

   // The output slot can take a new word when it is empty or being drained this cycle.
   assign slot_free  = !ft_valid || ft_ready;
   assign iq_ready   = !reset && slot_free && !flush_pending;
   assign accept     = iq_valid && iq_ready;
   assign flush_exec = flush_pending && slot_free;
   assign phase      = phase_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      phase_d         = phase_q;
      residual_d      = residual_q;
      data_d          = ft_data;
      be_d            = ft_be;
      valid_d         = ft_valid && !ft_ready;
      flush_pending_d = flush_pending || flush;

      if (accept) begin
         unique case (phase_q)
            PH0: begin
               residual_d = iq_data;
               phase_d    = PH1;
            end
            PH1: begin
               data_d     = {iq_data[7:0], residual_q};
               be_d       = 4'b1111;
               valid_d    = 1'b1;
               residual_d = {8'h00, iq_data[23:8]};
               phase_d    = PH2;
            end
            PH2: begin
               data_d     = {iq_data[15:0], residual_q[15:0]};
               be_d       = 4'b1111;
               valid_d    = 1'b1;
               residual_d = {16'h0000, iq_data[23:16]};
               phase_d    = PH3;
            end
            PH3: begin
               data_d     = {iq_data, residual_q[7:0]};
               be_d       = 4'b1111;
               valid_d    = 1'b1;
               residual_d = 24'h0;
               phase_d    = PH0;
            end
            default: ;
         endcase
      end else if (flush_exec) begin
         // A flush arriving on the executing edge is absorbed into this one.
         flush_pending_d = 1'b0;
         phase_d         = PH0;
         residual_d      = 24'h0;
         unique case (phase_q)
            PH1: begin
               data_d  = {8'h00, residual_q};
               be_d    = 4'b0111;
               valid_d = 1'b1;
            end
            PH2: begin
               data_d  = {16'h0000, residual_q[15:0]};
               be_d    = 4'b0011;
               valid_d = 1'b1;
            end
            PH3: begin
               data_d  = {24'h0, residual_q[7:0]};
               be_d    = 4'b0001;
               valid_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         phase_q       <= PH0;
         residual_q    <= 24'h0;
         ft_data       <= '0;
         ft_be         <= 4'b0000;
         ft_valid      <= 1'b0;
         flush_pending <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         residual_q    <= residual_d;
         ft_data       <= data_d;
         ft_be         <= be_d;
         ft_valid      <= valid_d;
         flush_pending <= flush_pending_d;
      end
   end

endmodule

// File: tb/tb_a2f_iq_packer.sv
// Self-checking bench for a2f_iq_packer: directed vector table, hand-written corner
// sequences, and a randomized stream checked against a byte-queue reference model.
module tb_a2f_iq_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] iq_data;
   logic        iq_valid;
   logic        iq_ready;
   logic        flush;
   logic [31:0] ft_data;
   logic [3:0]  ft_be;
   logic        ft_valid;
   logic        ft_ready;
   logic [1:0]  phase;
   logic        flush_pending;

   a2f_iq_packer dut (
      .clk           (clk),
      .reset         (reset),
      .iq_data       (iq_data),
      .iq_valid      (iq_valid),
      .iq_ready      (iq_ready),
      .flush         (flush),
      .ft_data       (ft_data),
      .ft_be         (ft_be),
      .ft_valid      (ft_valid),
      .ft_ready      (ft_ready),
      .phase         (phase),
      .flush_pending (flush_pending)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // Reference model: every accepted pair contributes three bytes, LSB first; every
   // transferred word must hand back the oldest outstanding bytes in its enabled lanes.
   logic [7:0]  exp_bytes[$];
   logic [35:0] got_q[$];
   logic        hold_v = 1'b0;
   logic [31:0] hold_d;
   logic [3:0]  hold_be;

   always @(negedge clk) begin
      if (reset) begin
         exp_bytes.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("stable_data", ft_data, hold_d);
            check("stable_be", {28'h0, ft_be}, {28'h0, hold_be});
         end
         if (iq_valid && iq_ready) begin
            exp_bytes.push_back(iq_data[7:0]);
            exp_bytes.push_back(iq_data[15:8]);
            exp_bytes.push_back(iq_data[23:16]);
         end
         if (ft_valid && ft_ready) begin
            got_q.push_back({ft_be, ft_data});
            check("be_shape", {31'h0, (ft_be == 4'hf || ft_be == 4'h7 ||
                                       ft_be == 4'h3 || ft_be == 4'h1)}, 32'h1);
            for (int n = 0; n < 4; n++) begin
               if (ft_be[n]) begin
                  if (exp_bytes.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL stream_extra_byte: got=%h want=none", ft_data[8*n +: 8]);
                  end else begin
                     check("stream_byte", {24'h0, ft_data[8*n +: 8]}, {24'h0, exp_bytes.pop_front()});
                  end
               end else begin
                  check("unused_lane_zero", {24'h0, ft_data[8*n +: 8]}, 32'h0);
               end
            end
         end
         hold_v  = ft_valid && !ft_ready;
         hold_d  = ft_data;
         hold_be = ft_be;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      iq_valid = 1'b0;
      flush    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic send(input logic [23:0] d);
      int w = 0;
      iq_data  = d;
      iq_valid = 1'b1;
      @(negedge clk);
      while (!iq_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("send_ready", {31'h0, iq_ready}, 32'h1);
      @(posedge clk);
      #1;
      iq_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   typedef struct {
      int               npairs;
      logic [3:0][23:0] pairs;
      logic             do_flush;
      int               nwords;
      logic [3:0][31:0] words;
      logic [3:0][3:0]  bes;
   } vec_t;

   vec_t vecs[5];
   int   sent;
   int   cyc;
   int   w;

   initial begin
      vecs[0] = '{npairs: 4, pairs: {24'hD1D2D3, 24'hC1C2C3, 24'hB1B2B3, 24'hA1A2A3}, do_flush: 1'b0,
                  nwords: 3, words: {32'h0, 32'hD1D2D3C1, 32'hC2C3B1B2, 32'hB3A1A2A3},
                  bes: {4'h0, 4'hf, 4'hf, 4'hf}};
      vecs[1] = '{npairs: 2, pairs: {24'h0, 24'h0, 24'h222222, 24'h111111}, do_flush: 1'b1,
                  nwords: 2, words: {32'h0, 32'h0, 32'h00002222, 32'h22111111},
                  bes: {4'h0, 4'h0, 4'h3, 4'hf}};
      vecs[2] = '{npairs: 1, pairs: {24'h0, 24'h0, 24'h0, 24'hABCDEF}, do_flush: 1'b1,
                  nwords: 1, words: {32'h0, 32'h0, 32'h0, 32'h00ABCDEF},
                  bes: {4'h0, 4'h0, 4'h0, 4'h7}};
      vecs[3] = '{npairs: 0, pairs: '0, do_flush: 1'b1,
                  nwords: 0, words: '0, bes: '0};
      vecs[4] = '{npairs: 3, pairs: {24'h0, 24'hDEF012, 24'h789ABC, 24'h123456}, do_flush: 1'b1,
                  nwords: 3, words: {32'h0, 32'h000000DE, 32'hF012789A, 32'hBC123456},
                  bes: {4'h0, 4'h1, 4'hf, 4'hf}};

      iq_data  = 24'h0;
      ft_ready = 1'b0;
      reset    = 1'b1;
      iq_valid = 1'b0;
      flush    = 1'b0;
      tick();
      tick();
      check("rst_ft_valid", {31'h0, ft_valid}, 32'h0);
      check("rst_ft_data", ft_data, 32'h0);
      check("rst_ft_be", {28'h0, ft_be}, 32'h0);
      check("rst_phase", {30'h0, phase}, 32'h0);
      check("rst_flush_pending", {31'h0, flush_pending}, 32'h0);
      check("rst_iq_ready", {31'h0, iq_ready}, 32'h0);
      reset = 1'b0;
      #1;
      check("post_rst_iq_ready", {31'h0, iq_ready}, 32'h1);

      // Directed vector table.
      foreach (vecs[i]) begin
         do_reset();
         got_q.delete();
         ft_ready = 1'b1;
         for (int p = 0; p < vecs[i].npairs; p++) send(vecs[i].pairs[p]);
         if (vecs[i].do_flush) pulse_flush();
         repeat (6) tick();
         check($sformatf("vec%0d_nwords", i), got_q.size(), vecs[i].nwords);
         for (int k = 0; k < vecs[i].nwords && k < got_q.size(); k++) begin
            check($sformatf("vec%0d_word%0d", i, k), got_q[k][31:0], vecs[i].words[k]);
            check($sformatf("vec%0d_be%0d", i, k), {28'h0, got_q[k][35:32]}, {28'h0, vecs[i].bes[k]});
         end
         check($sformatf("vec%0d_phase", i), {30'h0, phase}, 32'h0);
         check($sformatf("vec%0d_flush_pending", i), {31'h0, flush_pending}, 32'h0);
      end

      // Flush at phase 0: latched for one cycle, then cleared without a word.
      do_reset();
      ft_ready = 1'b1;
      pulse_flush();
      check("ph0_flush_latched", {31'h0, flush_pending}, 32'h1);
      check("ph0_flush_iq_ready", {31'h0, iq_ready}, 32'h0);
      tick();
      check("ph0_flush_cleared", {31'h0, flush_pending}, 32'h0);
      check("ph0_flush_no_word", {31'h0, ft_valid}, 32'h0);

      // Reset mid-group with a word stuck in the slot discards everything pre-reset.
      do_reset();
      ft_ready = 1'b0;
      send(24'h111111);
      send(24'h222222);
      check("pre_rst_pending", {31'h0, ft_valid}, 32'h1);
      reset = 1'b1;
      tick();
      check("mid_rst_ft_valid", {31'h0, ft_valid}, 32'h0);
      check("mid_rst_phase", {30'h0, phase}, 32'h0);
      reset    = 1'b0;
      ft_ready = 1'b1;
      got_q.delete();
      send(24'h445566);
      send(24'h778899);
      send(24'hAABBCC);
      send(24'hDDEEFF);
      repeat (4) tick();
      check("post_rst_nwords", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("post_rst_w0", got_q[0][31:0], 32'h99445566);
         check("post_rst_w1", got_q[1][31:0], 32'hBBCC7788);
         check("post_rst_w2", got_q[2][31:0], 32'hDDEEFFAA);
      end

      // Randomized stream with gaps, back-pressure and occasional flushes.
      do_reset();
      sent = 0;
      cyc  = 0;
      while (sent < 400 && cyc < 20000) begin
         iq_valid = ($urandom_range(0, 3) != 0);
         iq_data  = 24'($urandom);
         ft_ready = ($urandom_range(0, 9) < 7);
         flush    = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         if (iq_valid && iq_ready) sent++;
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rand_sent", sent, 400);
      iq_valid = 1'b0;
      ft_ready = 1'b1;
      pulse_flush();
      w = 0;
      while ((flush_pending || ft_valid) && w < 50) begin
         tick();
         w++;
      end
      tick();
      check("rand_drain_pending", {31'h0, flush_pending}, 32'h0);
      check("rand_drain_valid", {31'h0, ft_valid}, 32'h0);
      check("rand_bytes_left", exp_bytes.size(), 0);
      check("rand_phase", {30'h0, phase}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
